// File: rtl/ped_request_ctrl.sv
// Pedestrian request front-end: synchronises and debounces the push-button, requests a crossing
// from the light sequencer and drives the walk lamp. Optional request timeout: `define REQ_TIMEOUT_EN.
module ped_request_ctrl #(
    parameter int DEB_CYCLES     = 4,
    parameter int COOL_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Button,
    input  logic [2:0] Lights,
    output logic       Start,
    output logic       WalkReq,
    output logic       Walk,
    output logic       Busy,
    output logic       Fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB,
        S_PEND,
        S_WALK,
        S_COOL
    } state_e;

    typedef struct packed {
        logic start;
        logic walk_req;
        logic walk;
        logic busy;
    } outs_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Moore output pattern of a state; used when registering a transition into that state.
    function automatic outs_t decode(input state_e s);
        outs_t o;
        o.start    = (s == S_PEND);
        o.walk_req = (s == S_PEND);
        o.walk     = (s == S_WALK);
        o.busy     = (s != S_IDLE);
        return o;
    endfunction

    state_e           r_state;
    outs_t            r_out;
    logic             r_sync1;
    logic             r_btn_s;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_cool_cnt;
    logic             w_red;

    assign w_red = (Lights == 3'b100);

`ifdef REQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_fault;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(negedge Clk) begin
        if (!nReset) begin
            r_state    <= S_IDLE;
            r_out      <= '0;
            r_sync1    <= 1'b0;
            r_btn_s    <= 1'b0;
            r_deb_cnt  <= '0;
            r_cool_cnt <= '0;
`ifdef REQ_TIMEOUT_EN
            r_to_cnt   <= '0;
            r_fault    <= 1'b0;
`endif
        end else begin
            r_sync1 <= Button;
            r_btn_s <= r_sync1;
            case (r_state)
                S_IDLE: begin
                    if (r_btn_s) begin
                        r_state   <= S_DEB;
                        r_out     <= decode(S_DEB);
                        r_deb_cnt <= CNT_ONE;
                    end
                end
                S_DEB: begin
                    if (!r_btn_s) begin
                        r_state   <= S_IDLE;
                        r_out     <= decode(S_IDLE);
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state   <= S_PEND;
                        r_out     <= decode(S_PEND);
                        r_deb_cnt <= '0;
`ifdef REQ_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                    end else begin
                        r_deb_cnt <= r_deb_cnt + CNT_ONE;
                    end
                end
                S_PEND: begin
                    if (w_red) begin
                        r_state <= S_WALK;
                        r_out   <= decode(S_WALK);
`ifdef REQ_TIMEOUT_EN
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state    <= S_COOL;
                        r_out      <= decode(S_COOL);
                        r_cool_cnt <= COOL_LOAD;
                        r_fault    <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + CNT_ONE;
`endif
                    end
                end
                S_WALK: begin
                    if (!w_red) begin
                        r_state    <= S_COOL;
                        r_out      <= decode(S_COOL);
                        r_cool_cnt <= COOL_LOAD;
                    end
                end
                S_COOL: begin
                    // A button still held at the end of cooldown keeps us here until released.
                    if (r_cool_cnt != '0) begin
                        r_cool_cnt <= r_cool_cnt - CNT_ONE;
                    end else if (!r_btn_s) begin
                        r_state <= S_IDLE;
                        r_out   <= decode(S_IDLE);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_out   <= decode(S_IDLE);
                end
            endcase
        end
    end

    assign Start   = r_out.start;
    assign WalkReq = r_out.walk_req;
    assign Walk    = r_out.walk;
    assign Busy    = r_out.busy;

`ifdef REQ_TIMEOUT_EN
    assign Fault = r_fault;
`else
    assign Fault = 1'b0;
`endif

endmodule
